// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcodes, one-hot class bit indices, funct constants and the FIFO entry type
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum int {
        T_JALR   = 0,
        T_AUIPC  = 1,
        T_LUI    = 2,
        T_JAL    = 3,
        T_BRANCH = 4,
        T_STORE  = 5,
        T_LOAD   = 6,
        T_IALU   = 7,
        T_R      = 8
    } type_bit_e;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SRX  = 3'd5;
    localparam logic [2:0] F3_SW   = 3'd2;
    localparam logic [2:0] F3_JALR = 3'd0;
    localparam logic [2:0] F3_BR2  = 3'd2;
    localparam logic [2:0] F3_BR3  = 3'd3;
    localparam logic [2:0] F3_LD3  = 3'd3;
    localparam logic [2:0] F3_LD6  = 3'd6;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef struct packed {
        logic        illegal;
        logic [31:0] instr;
    } entry_t;

    // true when v, read as signed, fits in an n-bit two's-complement field
    function automatic logic fits_signed(logic [31:0] v, int n);
        logic [31:0] s;
        s = 32'($signed(v) >>> (n - 1));
        return (s == 32'h0) || (s == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/inst_enc_fifo.sv
// inst_enc_fifo: synchronous FIFO of encoded entries; head holds the last popped entry while empty
module inst_enc_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output logic   full,
    output logic   empty,
    output entry_t dout
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    entry_t        mem [DEPTH];
    entry_t        last;
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;

    assign full    = cnt == FULL_CNT;
    assign empty   = cnt == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? last : mem[rp];

    // storage write, no reset needed since only occupied slots are ever read
    always_ff @(posedge clock) begin
        if (do_push) mem[wp] <= din;
    end

    // pointers, occupancy and the held copy of the last popped entry
    always_ff @(posedge clock) begin
        if (reset) begin
            wp   <= '0;
            rp   <= '0;
            cnt  <= '0;
            last <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop) begin
                rp   <= rp + AW'(1);
                last <= mem[rp];
            end
            cnt <= cnt + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded fields into RV32I words and queues them; INST_ENC_CHECK_EN adds legality checking
module inst_encoder
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       itype,
    input  logic [2:0]       f3,
    input  logic [6:0]       f7,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [31:0]      immediate,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             illegal,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);
    logic        full, empty, accept, is_shift;
    logic [31:0] raw;
    entry_t      enc, head;

    assign accept   = in_valid && in_ready;
    assign in_ready = !full;
    assign is_shift = itype[T_IALU] && (f3 == F3_SLL || f3 == F3_SRX);

    // field packing; highest class bit wins if several are set and nothing checks it
    always_comb begin
        raw = itype[T_R]      ? {f7, rs2, rs1, f3, rd, OP_R} :
              itype[T_IALU]   ? (is_shift ? {f7, immediate[4:0], rs1, f3, rd, OP_I}
                                          : {immediate[11:0], rs1, f3, rd, OP_I}) :
              itype[T_LOAD]   ? {immediate[11:0], rs1, f3, rd, OP_LOAD} :
              itype[T_STORE]  ? {immediate[11:5], rs2, rs1, f3, immediate[4:0], OP_STORE} :
              itype[T_BRANCH] ? {immediate[12], immediate[10:5], rs2, rs1, f3,
                                 immediate[4:1], immediate[11], OP_BRANCH} :
              itype[T_JAL]    ? {immediate[20], immediate[10:1], immediate[11],
                                 immediate[19:12], rd, OP_JAL} :
              itype[T_LUI]    ? {immediate[31:12], rd, OP_LUI} :
              itype[T_AUIPC]  ? {immediate[31:12], rd, OP_AUIPC} :
              itype[T_JALR]   ? {immediate[11:0], rs1, F3_JALR, rd, OP_JALR} :
                                32'h0;
    end

`ifdef INST_ENC_CHECK_EN
    logic f7_ok, multi, fit12, bad;

    // legality check: class one-hot, funct fields valid, immediate representable
    always_comb begin
        f7_ok = (f7 == F7_BASE) || (f7 == F7_ALT);
        multi = (itype & (itype - 9'd1)) != 9'd0;
        fit12 = fits_signed(immediate, 12);
        bad   = multi
             || (itype[T_R] && (!f7_ok || (f7 == F7_ALT && f3 != F3_ADD && f3 != F3_SRX)))
             || (itype[T_IALU] && (!fit12 || (is_shift && (!f7_ok || (f7 == F7_ALT && f3 == F3_SLL)))))
             || (itype[T_LOAD] && (!fit12 || f3 == F3_LD3 || f3 >= F3_LD6))
             || (itype[T_STORE] && (!fit12 || f3 > F3_SW))
             || (itype[T_BRANCH] && (!fits_signed(immediate, 13) || immediate[0] || f3 == F3_BR2 || f3 == F3_BR3))
             || (itype[T_JAL] && (!fits_signed(immediate, 21) || immediate[0]))
             || ((itype[T_LUI] || itype[T_AUIPC]) && immediate[11:0] != 12'h0)
             || (itype[T_JALR] && (!fit12 || f3 != F3_JALR));
    end

    assign enc = '{illegal: bad, instr: bad ? 32'h0 : raw};

    // illegal-instruction counter, wraps naturally
    always_ff @(posedge clock) begin
        if (reset) err_count <= '0;
        else if (accept && bad) err_count <= err_count + CNT_W'(1);
    end
`else
    assign enc       = '{illegal: 1'b0, instr: raw};
    assign err_count = '0;
`endif

    // accepted-instruction counter, wraps naturally
    always_ff @(posedge clock) begin
        if (reset) enc_count <= '0;
        else if (accept) enc_count <= enc_count + CNT_W'(1);
    end

    inst_enc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (accept),
        .pop   (out_ready),
        .din   (enc),
        .full  (full),
        .empty (empty),
        .dout  (head)
    );

    assign out_valid = !empty;
    assign instr     = head.instr;
    assign illegal   = head.illegal;

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: table vectors, handshake corner sequences and randomized traffic against a queue model
module tb_inst_encoder;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [8:0]  itype = '0;
    logic [2:0]  f3 = '0;
    logic [6:0]  f7 = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] immediate = '0;
    logic        in_ready, out_valid, illegal;
    logic [31:0] instr;
    logic [15:0] enc_count, err_count;

    inst_encoder #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .itype(itype), .f3(f3), .f7(f7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .immediate(immediate), .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .illegal(illegal), .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [8:0]  t;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
    } fields_t;

    typedef struct {
        fields_t     f;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    int          checks = 0, errors = 0;
    logic [32:0] q[$];
    logic [32:0] last_pop = '0;
    logic [15:0] m_enc = '0, m_err = '0;
    vec_t        vecs[$];

    task automatic chk(string name, logic [32:0] act, logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic fields_t mk(logic [8:0] t, logic [2:0] a, logic [6:0] b,
                                   logic [4:0] d, logic [4:0] s1, logic [4:0] s2, logic [31:0] imm);
        fields_t f;
        f.t = t; f.f3 = a; f.f7 = b; f.rd = d; f.rs1 = s1; f.rs2 = s2; f.imm = imm;
        return f;
    endfunction

    function automatic logic [31:0] fld(logic [31:0] v, int lo, int n);
        return (v >> lo) & ((32'd1 << n) - 32'd1);
    endfunction

    // reference: build the word by shifting fields into place, judge legality by integer ranges
    function automatic logic [32:0] model(fields_t f);
        logic [31:0] w, i, base;
        int          s;
        bit          bad, f7ok, sh;
        i    = f.imm;
        s    = int'($signed(f.imm));
        w    = 32'h0;
        bad  = 1'b0;
        f7ok = (f.f7 == 7'h00) || (f.f7 == 7'h20);
        base = (32'(f.rs1) << 15) | (32'(f.f3) << 12) | (32'(f.rd) << 7);
        if ($countones(f.t) > 1) bad = 1'b1;
        else if (f.t[8]) begin
            w   = (32'(f.f7) << 25) | (32'(f.rs2) << 20) | base | 32'h33;
            bad = !f7ok || (f.f7 == 7'h20 && !(f.f3 == 0 || f.f3 == 5));
        end else if (f.t[7]) begin
            sh  = (f.f3 == 1) || (f.f3 == 5);
            w   = (sh ? ((32'(f.f7) << 25) | (fld(i, 0, 5) << 20)) : (fld(i, 0, 12) << 20)) | base | 32'h13;
            bad = s < -2048 || s > 2047 || (sh && (!f7ok || (f.f7 == 7'h20 && f.f3 == 1)));
        end else if (f.t[6]) begin
            w   = (fld(i, 0, 12) << 20) | base | 32'h03;
            bad = s < -2048 || s > 2047 || f.f3 == 3 || f.f3 == 6 || f.f3 == 7;
        end else if (f.t[5]) begin
            w   = (fld(i, 5, 7) << 25) | (32'(f.rs2) << 20) | (32'(f.rs1) << 15) | (32'(f.f3) << 12)
                | (fld(i, 0, 5) << 7) | 32'h23;
            bad = s < -2048 || s > 2047 || f.f3 > 2;
        end else if (f.t[4]) begin
            w   = (fld(i, 12, 1) << 31) | (fld(i, 5, 6) << 25) | (32'(f.rs2) << 20) | (32'(f.rs1) << 15)
                | (32'(f.f3) << 12) | (fld(i, 1, 4) << 8) | (fld(i, 11, 1) << 7) | 32'h63;
            bad = s < -4096 || s > 4095 || i[0] || f.f3 == 2 || f.f3 == 3;
        end else if (f.t[3]) begin
            w   = (fld(i, 20, 1) << 31) | (fld(i, 1, 10) << 21) | (fld(i, 11, 1) << 20)
                | (fld(i, 12, 8) << 12) | (32'(f.rd) << 7) | 32'h6F;
            bad = s < -1048576 || s > 1048575 || i[0];
        end else if (f.t[2] || f.t[1]) begin
            w   = (i & 32'hFFFF_F000) | (32'(f.rd) << 7) | (f.t[2] ? 32'h37 : 32'h17);
            bad = (i & 32'hFFF) != 0;
        end else if (f.t[0]) begin
            w   = (fld(i, 0, 12) << 20) | (32'(f.rs1) << 15) | (32'(f.rd) << 7) | 32'h67;
            bad = s < -2048 || s > 2047 || f.f3 != 0;
        end
`ifdef INST_ENC_CHECK_EN
        if (bad) w = 32'h0;
`else
        bad = 1'b0;
`endif
        return {bad, w};
    endfunction

    // one cycle: check state against the model, drive inputs, advance model at the edge
    task automatic tick(bit iv, bit ordy, fields_t f);
        bit          push, pop;
        logic [32:0] e;
        in_valid = iv; out_ready = ordy;
        itype = f.t; f3 = f.f3; f7 = f.f7; rd = f.rd; rs1 = f.rs1; rs2 = f.rs2; immediate = f.imm;
        chk("in_ready", 33'(in_ready), 33'(q.size() < DEPTH));
        chk("out_valid", 33'(out_valid), 33'(q.size() > 0));
        chk("head", {illegal, instr}, q.size() > 0 ? q[0] : last_pop);
        chk("enc_count", 33'(enc_count), 33'(m_enc));
        chk("err_count", 33'(err_count), 33'(m_err));
        push = iv && q.size() < DEPTH;
        pop  = ordy && q.size() > 0;
        e    = model(f);
        @(posedge clock); #1;
        if (pop) last_pop = q.pop_front();
        if (push) begin
            q.push_back(e);
            m_enc++;
            if (e[32]) m_err++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic do_reset(bit iv);
        in_valid = iv;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; in_valid = 1'b0;
        q.delete(); last_pop = '0; m_enc = '0; m_err = '0;
    endtask

    function automatic fields_t rnd();
        fields_t     f;
        int unsigned k;
        k = $urandom_range(0, 10);
`ifdef INST_ENC_CHECK_EN
        f.t = k < 9 ? 9'(1 << k) : (k == 9 ? 9'h0 : 9'($urandom));
`else
        f.t = k < 9 ? 9'(1 << k) : (k == 9 ? 9'h0 : 9'(1 << $urandom_range(0, 8)));
`endif
        f.f3  = 3'($urandom);
        f.f7  = $urandom_range(0, 3) == 0 ? 7'($urandom) : ($urandom_range(0, 1) ? 7'h20 : 7'h00);
        f.rd  = 5'($urandom); f.rs1 = 5'($urandom); f.rs2 = 5'($urandom);
        case ($urandom_range(0, 4))
            0: f.imm = $urandom;
            1: f.imm = 32'(int'($urandom_range(0, 8191)) - 4096);
            2: f.imm = $urandom & 32'hFFFF_F000;
            3: f.imm = 32'(int'($urandom_range(0, 4095)) - 2048) & ~32'h1;
            default: f.imm = 32'(int'($urandom_range(0, 2097151)) - 1048576);
        endcase
        return f;
    endfunction

    fields_t idle;

    initial begin
        idle = mk(9'h0, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
        vecs.push_back('{mk(9'h100, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0), 32'h002081B3, 1'b0});
        vecs.push_back('{mk(9'h010, 3'd0, 7'h00, 5'd0, 5'd5, 5'd6, -32'sd4), 32'hFE628EE3, 1'b0});
`ifdef INST_ENC_CHECK_EN
        vecs.push_back('{mk(9'h010, 3'd0, 7'h00, 5'd0, 5'd5, 5'd6, 32'd3), 32'h00000000, 1'b1});
        vecs.push_back('{mk(9'h180, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0), 32'h00000000, 1'b1});
        vecs.push_back('{mk(9'h100, 3'd1, 7'h20, 5'd3, 5'd1, 5'd2, 32'h0), 32'h00000000, 1'b1});
`else
        vecs.push_back('{mk(9'h010, 3'd0, 7'h00, 5'd0, 5'd5, 5'd6, 32'd3), 32'h00628163, 1'b0});
`endif
        vecs.push_back('{mk(9'h008, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048), 32'h001000EF, 1'b0});
        vecs.push_back('{mk(9'h040, 3'd2, 7'h00, 5'd7, 5'd2, 5'd0, -32'sd8), 32'hFF812383, 1'b0});
        vecs.push_back('{mk(9'h004, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000), 32'h123452B7, 1'b0});
        vecs.push_back('{mk(9'h080, 3'd5, 7'h20, 5'd1, 5'd2, 5'd0, 32'd3), 32'h40315093, 1'b0});
        vecs.push_back('{mk(9'h020, 3'd2, 7'h00, 5'd0, 5'd2, 5'd9, 32'd12), 32'h00912623, 1'b0});
        vecs.push_back('{mk(9'h001, 3'd0, 7'h00, 5'd1, 5'd6, 5'd0, 32'd4), 32'h004300E7, 1'b0});
        vecs.push_back('{mk(9'h000, 3'd0, 7'h00, 5'd1, 5'd6, 5'd0, 32'd4), 32'h00000000, 1'b0});

        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("reset out_valid", 33'(out_valid), 33'd0);
        chk("reset in_ready", 33'(in_ready), 33'd1);
        chk("reset head", {illegal, instr}, 33'd0);
        chk("reset enc_count", 33'(enc_count), 33'd0);
        chk("reset err_count", 33'(err_count), 33'd0);

        foreach (vecs[i]) begin
            tick(1'b1, 1'b0, vecs[i].f);
            chk("vec valid", 33'(out_valid), 33'd1);
            chk("vec word", {illegal, instr}, {vecs[i].ill, vecs[i].exp});
            if (i == 0) chk("first enc_count", 33'(enc_count), 33'd1);
            tick(1'b0, 1'b1, idle);
            chk("vec drained", 33'(out_valid), 33'd0);
            chk("vec hold", {illegal, instr}, {vecs[i].ill, vecs[i].exp});
        end

        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, mk(9'h100, 3'd0, 7'h00, 5'(i + 1), 5'd1, 5'd2, 32'h0));
        chk("full in_ready", 33'(in_ready), 33'd0);
        tick(1'b1, 1'b0, mk(9'h100, 3'd0, 7'h00, 5'd5, 5'd1, 5'd2, 32'h0));
        chk("held enc_count", 33'(enc_count), 33'(m_enc));
        tick(1'b1, 1'b1, mk(9'h100, 3'd0, 7'h00, 5'd5, 5'd1, 5'd2, 32'h0));
        chk("slot freed", 33'(in_ready), 33'd1);
        tick(1'b1, 1'b0, mk(9'h100, 3'd0, 7'h00, 5'd5, 5'd1, 5'd2, 32'h0));
        for (int i = 2; i <= 5; i++) begin
            chk("bp order", 33'(instr[11:7]), 33'(i));
            tick(1'b0, 1'b1, idle);
        end

        tick(1'b1, 1'b0, mk(9'h100, 3'd0, 7'h00, 5'd10, 5'd1, 5'd2, 32'h0));
        tick(1'b1, 1'b0, mk(9'h100, 3'd0, 7'h00, 5'd11, 5'd1, 5'd2, 32'h0));
        tick(1'b1, 1'b1, mk(9'h100, 3'd0, 7'h00, 5'd12, 5'd1, 5'd2, 32'h0));
        chk("pushpop head", 33'(instr[11:7]), 33'd11);
        tick(1'b0, 1'b1, idle);
        chk("pushpop next", 33'(instr[11:7]), 33'd12);
        tick(1'b0, 1'b1, idle);
        chk("pushpop empty", 33'(out_valid), 33'd0);

        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, mk(9'h100, 3'd0, 7'h00, 5'(i), 5'd1, 5'd2, 32'h0));
        do_reset(1'b1);
        chk("flush out_valid", 33'(out_valid), 33'd0);
        chk("flush enc_count", 33'(enc_count), 33'd0);
        chk("flush err_count", 33'(err_count), 33'd0);
        chk("flush in_ready", 33'(in_ready), 33'd1);
        chk("flush head", {illegal, instr}, 33'd0);

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0) do_reset($urandom_range(0, 1) == 1);
            else tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rnd());
        end
        tick(1'b0, 1'b0, idle);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
